// File: rtl/apb_uart_regs_if.sv
// ---------------------------------------------------------------------------
// apb_uart_regs_if
//
// APB3 bus bundle between the system APB bridge (master) and the UART
// register front-end (slave).
//
// Signals:
//   psel     - slave select
//   penable  - ACCESS phase marker
//   pwrite   - 1 = write, 0 = read
//   paddr    - byte address (ADDR_W bits)
//   pwdata   - write data
//   prdata   - read data, driven by the slave
//   pready   - transfer complete, driven by the slave
//   pslverr  - error response, valid while pready=1
// ---------------------------------------------------------------------------
interface apb_uart_regs_if #(
    parameter int ADDR_W = 4
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_uart_regs.sv
// ---------------------------------------------------------------------------
// apb_uart_regs
//
// APB3 slave register front-end for the UART controller. Turns CPU bus
// transfers into single-cycle push/pop strobes on the UART TX/RX FIFOs and
// holds the baud divisor, interrupt enables and sticky error flags.
//
// Register map (paddr[3:2]):
//   0 DATA   write pushes pwdata[7:0] to TX, read pops the RX head byte
//   1 STATUS RO: {rx_underflow, tx_drop, rx_empty, rx_full, tx_empty, tx_full}
//   2 BAUD   RW: baud divisor [BAUD_W-1:0]
//   3 CTRL   RW: bit0 rx_ie, bit1 tx_ie; write 1 to bit4/bit5 clears
//            tx_drop / rx_underflow (these bits read as 0)
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-low reset
//   apb               APB3 slave modport (psel/penable/pwrite/paddr/pwdata in,
//                     prdata/pready/pslverr out)
//   tx_fifo_dataIn    byte pushed to the TX FIFO
//   tx_fifo_writeEn   one-cycle TX push strobe
//   tx_fifo_full      TX FIFO full
//   tx_fifo_empty     TX FIFO empty
//   rx_fifo_readEn    one-cycle RX pop strobe
//   rx_fifo_dataOut   RX FIFO head byte (show-ahead)
//   rx_fifo_empty     RX FIFO empty
//   rx_fifo_full      RX FIFO full
//   baud_final_value  baud divisor for the UART baud generator
//   irq               registered level interrupt
// ---------------------------------------------------------------------------
module apb_uart_regs #(
    parameter int ADDR_W   = 4,
    parameter int BAUD_W   = 11,
    parameter int BAUD_RST = 650
) (
    input  logic              clk,
    input  logic              reset,
    apb_uart_regs_if.slave    apb,
    output logic [7:0]        tx_fifo_dataIn,
    output logic              tx_fifo_writeEn,
    input  logic              tx_fifo_full,
    input  logic              tx_fifo_empty,
    output logic              rx_fifo_readEn,
    input  logic [7:0]        rx_fifo_dataOut,
    input  logic              rx_fifo_empty,
    input  logic              rx_fifo_full,
    output logic [BAUD_W-1:0] baud_final_value,
    output logic              irq
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    state_t            state_q;
    state_t            state_d;

    logic [ADDR_W-1:0] addr;
    logic [1:0]        reg_sel;
    logic              access;

    logic [BAUD_W-1:0] baud_q;
    logic              rx_ie_q;
    logic              tx_ie_q;
    logic              tx_drop_q;
    logic              rx_underflow_q;
    logic [31:0]       prdata_q;
    logic              pslverr_q;
    logic              irq_q;

    logic              tx_push;
    logic              rx_pop;
    logic              err;
    logic [31:0]       rdata;
    logic              set_tx_drop;
    logic              set_rx_underflow;
    logic              wr_baud;
    logic              wr_ctrl;

    logic              unused_bits;

    assign addr    = apb.paddr;
    assign reg_sel = addr[3:2];

    // Byte-lane bits and upper address/data bits are not decoded.
    assign unused_bits = ^{1'b0, addr, apb.pwdata};

    // State register. Reset drops the FSM back to IDLE at once, even in
    // the middle of a transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Only the first ACCESS cycle seen in IDLE starts a
    // transfer; RESP always lasts exactly one cycle so every transfer gets a
    // single wait state. Gating with reset keeps strobes low while reset is
    // asserted, since IDLE is the state in which strobes are produced.
    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (reset && apb.psel && apb.penable) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register decode for the access cycle: side-effect strobes, the read
    // value to capture and whether the transfer answers with an error.
    always_comb begin
        tx_push          = 1'b0;
        rx_pop           = 1'b0;
        err              = 1'b0;
        rdata            = 32'h0;
        set_tx_drop      = 1'b0;
        set_rx_underflow = 1'b0;
        wr_baud          = 1'b0;
        wr_ctrl          = 1'b0;
        if (access) begin
            case (reg_sel)
                REG_DATA: begin
                    if (apb.pwrite) begin
                        if (tx_fifo_full) begin
                            set_tx_drop = 1'b1;
                            err         = 1'b1;
                        end else begin
                            tx_push = 1'b1;
                        end
                    end else begin
                        if (rx_fifo_empty) begin
                            set_rx_underflow = 1'b1;
                            err              = 1'b1;
                        end else begin
                            rx_pop = 1'b1;
                            rdata  = {24'h0, rx_fifo_dataOut};
                        end
                    end
                end
                REG_STATUS: begin
                    if (apb.pwrite) begin
                        err = 1'b1;
                    end else begin
                        rdata = {26'h0, rx_underflow_q, tx_drop_q,
                                 rx_fifo_empty, rx_fifo_full,
                                 tx_fifo_empty, tx_fifo_full};
                    end
                end
                REG_BAUD: begin
                    if (apb.pwrite) begin
                        wr_baud = 1'b1;
                    end else begin
                        rdata = {{(32-BAUD_W){1'b0}}, baud_q};
                    end
                end
                default: begin
                    if (apb.pwrite) begin
                        wr_ctrl = 1'b1;
                    end else begin
                        rdata = {30'h0, tx_ie_q, rx_ie_q};
                    end
                end
            endcase
        end
    end

    // Response capture. pslverr is reloaded every cycle, so it is only ever
    // high during the RESP cycle following an erroring access. prdata holds
    // its last captured value between transfers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prdata_q  <= 32'h0;
            pslverr_q <= 1'b0;
        end else begin
            pslverr_q <= err;
            if (access) begin
                prdata_q <= rdata;
            end
        end
    end

    // Configuration registers and sticky error flags. A flag set takes
    // priority over a clear, although a single transfer cannot do both.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_q         <= BAUD_W'(BAUD_RST);
            rx_ie_q        <= 1'b0;
            tx_ie_q        <= 1'b0;
            tx_drop_q      <= 1'b0;
            rx_underflow_q <= 1'b0;
        end else begin
            if (wr_baud) begin
                baud_q <= apb.pwdata[BAUD_W-1:0];
            end
            if (wr_ctrl) begin
                rx_ie_q <= apb.pwdata[0];
                tx_ie_q <= apb.pwdata[1];
            end
            tx_drop_q      <= set_tx_drop |
                              (tx_drop_q & ~(wr_ctrl & apb.pwdata[4]));
            rx_underflow_q <= set_rx_underflow |
                              (rx_underflow_q & ~(wr_ctrl & apb.pwdata[5]));
        end
    end

    // Interrupt is registered, so it follows FIFO level changes one cycle
    // later and sticky flag sets two cycles after the erroring access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (rx_ie_q & ~rx_fifo_empty) | (tx_ie_q & tx_fifo_empty) |
                     tx_drop_q | rx_underflow_q;
        end
    end

    assign apb.prdata       = prdata_q;
    assign apb.pready       = (state_q == RESP);
    assign apb.pslverr      = pslverr_q;
    assign tx_fifo_writeEn  = tx_push;
    assign tx_fifo_dataIn   = tx_push ? apb.pwdata[7:0] : 8'h00;
    assign rx_fifo_readEn   = rx_pop;
    assign baud_final_value = baud_q;
    assign irq              = irq_q;

endmodule

// File: tb/tb_apb_uart_regs.sv
// ---------------------------------------------------------------------------
// tb_apb_uart_regs
//
// Directed bench for apb_uart_regs. Each APB transfer pushes its expected
// response onto a scoreboard queue; the entry is popped and compared when the
// DUT raises pready. FIFO strobes are counted on every falling edge so that
// push/pop pulses can be checked per transfer.
// ---------------------------------------------------------------------------
module tb_apb_uart_regs;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          is_read;
        string       tag;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  tx_fifo_dataIn;
    logic        tx_fifo_writeEn;
    logic        tx_fifo_full;
    logic        tx_fifo_empty;
    logic        rx_fifo_readEn;
    logic [7:0]  rx_fifo_dataOut;
    logic        rx_fifo_empty;
    logic        rx_fifo_full;
    logic [10:0] baud_final_value;
    logic        irq;

    int          n_checks;
    int          n_errors;
    int          tx_pulses;
    int          rx_pulses;
    logic [7:0]  last_tx_data;
    exp_t        sb[$];

    apb_uart_regs_if #(.ADDR_W(4)) bus ();

    apb_uart_regs #(
        .ADDR_W(4),
        .BAUD_W(11),
        .BAUD_RST(650)
    ) dut (
        .clk(clk),
        .reset(reset),
        .apb(bus.slave),
        .tx_fifo_dataIn(tx_fifo_dataIn),
        .tx_fifo_writeEn(tx_fifo_writeEn),
        .tx_fifo_full(tx_fifo_full),
        .tx_fifo_empty(tx_fifo_empty),
        .rx_fifo_readEn(rx_fifo_readEn),
        .rx_fifo_dataOut(rx_fifo_dataOut),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_full(rx_fifo_full),
        .baud_final_value(baud_final_value),
        .irq(irq)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobe monitor: one count per cycle the strobe is seen high
    always @(negedge clk) begin
        if (tx_fifo_writeEn) begin
            tx_pulses    = tx_pulses + 1;
            last_tx_data = tx_fifo_dataIn;
        end
        if (rx_fifo_readEn) begin
            rx_pulses = rx_pulses + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_errors = n_errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete APB transfer with scoreboard bookkeeping and strobe
    // counting; exp_tx/exp_rx are the push/pop pulses the transfer must cause.
    task automatic applyStimulus(input bit wr, input logic [3:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [31:0] exp_rd, input bit exp_err,
                                 input int exp_tx, input int exp_rx,
                                 input string tag);
        exp_t e;
        exp_t got;
        int   tx0;
        int   rx0;
        int   waited;
        e.rdata   = exp_rd;
        e.err     = exp_err;
        e.is_read = !wr;
        e.tag     = tag;
        sb.push_back(e);
        tx0 = tx_pulses;
        rx0 = rx_pulses;
        @(posedge clk);
        #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        @(posedge clk);
        #1;
        bus.penable = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.pready && waited < 4);
        got = sb.pop_front();
        if (!bus.pready) begin
            checkOutput({got.tag, "_pready_timeout"}, 32'(bus.pready), 32'd1);
        end else begin
            checkOutput({got.tag, "_latency"}, 32'(waited), 32'd2);
            if (got.is_read) begin
                checkOutput({got.tag, "_prdata"}, bus.prdata, got.rdata);
            end
            checkOutput({got.tag, "_pslverr"}, 32'(bus.pslverr), 32'(got.err));
        end
        @(posedge clk);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_pready_low"}, 32'(bus.pready), 32'd0);
        checkOutput({tag, "_tx_pulses"}, 32'(tx_pulses - tx0), 32'(exp_tx));
        checkOutput({tag, "_rx_pulses"}, 32'(rx_pulses - rx0), 32'(exp_rx));
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        tx_pulses       = 0;
        rx_pulses       = 0;
        last_tx_data    = 8'h00;
        reset           = 1'b0;
        bus.psel        = 1'b0;
        bus.penable     = 1'b0;
        bus.pwrite      = 1'b0;
        bus.paddr       = 4'h0;
        bus.pwdata      = 32'h0;
        tx_fifo_full    = 1'b0;
        tx_fifo_empty   = 1'b1;
        rx_fifo_full    = 1'b0;
        rx_fifo_empty   = 1'b1;
        rx_fifo_dataOut = 8'h00;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pready", 32'(bus.pready), 32'd0);
        checkOutput("rst_pslverr", 32'(bus.pslverr), 32'd0);
        checkOutput("rst_prdata", bus.prdata, 32'h0);
        checkOutput("rst_writeEn", 32'(tx_fifo_writeEn), 32'd0);
        checkOutput("rst_readEn", 32'(rx_fifo_readEn), 32'd0);
        checkOutput("rst_baud", 32'(baud_final_value), 32'd650);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        $display("[TB] baud and status after reset");
        applyStimulus(1'b0, 4'h8, 32'h0, 32'd650, 1'b0, 0, 0, "rd_baud_rst");
        applyStimulus(1'b0, 4'h4, 32'h0, 32'h0A, 1'b0, 0, 0, "rd_status_rst");

        $display("[TB] TX push");
        applyStimulus(1'b1, 4'h0, 32'hFFFF_FF55, 32'h0, 1'b0, 1, 0, "wr_data_55");
        checkOutput("tx_data_55", 32'(last_tx_data), 32'h55);

        $display("[TB] TX drop");
        tx_fifo_full  = 1'b1;
        tx_fifo_empty = 1'b0;
        applyStimulus(1'b1, 4'h0, 32'h0F, 32'h0, 1'b1, 0, 0, "wr_data_full");
        tx_fifo_full  = 1'b0;
        tx_fifo_empty = 1'b1;
        applyStimulus(1'b0, 4'h4, 32'h0, 32'h1A, 1'b0, 0, 0, "rd_status_drop");
        checkOutput("irq_tx_drop", 32'(irq), 32'd1);
        applyStimulus(1'b1, 4'hC, 32'h10, 32'h0, 1'b0, 0, 0, "wr_ctrl_clr_drop");
        applyStimulus(1'b0, 4'h4, 32'h0, 32'h0A, 1'b0, 0, 0, "rd_status_nodrop");
        applyStimulus(1'b1, 4'h4, 32'h3F, 32'h0, 1'b1, 0, 0, "wr_status");

        $display("[TB] RX pop and underflow");
        rx_fifo_dataOut = 8'hF0;
        rx_fifo_empty   = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0000_00F0, 1'b0, 0, 1, "rd_data_f0");
        rx_fifo_empty   = 1'b1;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 0, "rd_data_empty");
        applyStimulus(1'b0, 4'h4, 32'h0, 32'h2A, 1'b0, 0, 0, "rd_status_uf");
        applyStimulus(1'b1, 4'hC, 32'h20, 32'h0, 1'b0, 0, 0, "wr_ctrl_clr_uf");
        applyStimulus(1'b0, 4'h4, 32'h0, 32'h0A, 1'b0, 0, 0, "rd_status_nouf");

        $display("[TB] CTRL readback");
        applyStimulus(1'b1, 4'hC, 32'h32, 32'h0, 1'b0, 0, 0, "wr_ctrl_32");
        applyStimulus(1'b0, 4'hC, 32'h0, 32'h02, 1'b0, 0, 0, "rd_ctrl_02");
        checkOutput("irq_tx_ie", 32'(irq), 32'd1);

        $display("[TB] baud and irq");
        applyStimulus(1'b1, 4'h8, 32'h28B, 32'h0, 1'b0, 0, 0, "wr_baud");
        applyStimulus(1'b0, 4'h8, 32'h0, 32'h28B, 1'b0, 0, 0, "rd_baud");
        checkOutput("baud_out", 32'(baud_final_value), 32'd651);
        applyStimulus(1'b1, 4'hC, 32'h01, 32'h0, 1'b0, 0, 0, "wr_ctrl_01");
        checkOutput("irq_idle", 32'(irq), 32'd0);
        @(posedge clk);
        #1 rx_fifo_empty = 1'b0;
        @(negedge clk);
        checkOutput("irq_same_cycle", 32'(irq), 32'd0);
        @(negedge clk);
        checkOutput("irq_rx_ready", 32'(irq), 32'd1);
        @(posedge clk);
        #1 rx_fifo_empty = 1'b1;
        @(negedge clk);
        checkOutput("irq_hold", 32'(irq), 32'd1);
        @(negedge clk);
        checkOutput("irq_cleared", 32'(irq), 32'd0);

        $display("[TB] reset during access");
        begin
            int tx0;
            tx0 = tx_pulses;
            @(posedge clk);
            #1;
            bus.psel    = 1'b1;
            bus.penable = 1'b0;
            bus.pwrite  = 1'b1;
            bus.paddr   = 4'h0;
            bus.pwdata  = 32'hAA;
            @(posedge clk);
            #1 bus.penable = 1'b1;
            #1 checkOutput("abort_writeEn_before", 32'(tx_fifo_writeEn), 32'd1);
            #1 reset = 1'b0;
            #1;
            checkOutput("abort_writeEn_after", 32'(tx_fifo_writeEn), 32'd0);
            checkOutput("abort_dataIn", 32'(tx_fifo_dataIn), 32'h0);
            checkOutput("abort_pready", 32'(bus.pready), 32'd0);
            checkOutput("abort_baud", 32'(baud_final_value), 32'd650);
            @(negedge clk);
            checkOutput("abort_no_push", 32'(tx_pulses - tx0), 32'd0);
            @(posedge clk);
            #1;
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
            @(posedge clk);
            #1 reset = 1'b1;
            @(negedge clk);
            checkOutput("abort_pready_idle", 32'(bus.pready), 32'd0);
            checkOutput("abort_irq", 32'(irq), 32'd0);
        end
        applyStimulus(1'b0, 4'hC, 32'h0, 32'h0, 1'b0, 0, 0, "rd_ctrl_after_rst");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
